// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory stage:
//   - state_t    : FSM state encoding (IDLE, ACCESS)
//   - SIZE_*     : access size codes taken from funct3[1:0]
//   - BE_W/OFF_W : byte-enable width and byte-offset width
// No configuration macros are used in this file.
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int BE_W  = 4;
    localparam int OFF_W = 2;

    // funct3[1:0] selects the size; funct3[2] is the unsigned flag used downstream
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Signals:
//   req   : request, held until ack or abort
//   we    : 1 = store, 0 = load
//   addr  : word address, bits [1:0] always 0
//   be    : byte enables
//   wdata : lane-replicated store data
//   rdata : read data, valid with ack
//   ack   : memory completes the current request
// No configuration macros are used in this file.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic             req;
    logic             we;
    logic [31:0]      addr;
    logic [BE_W-1:0]  be;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );

endinterface

// File: rtl/mem_align.sv
// mem_align
// Combinational lane logic for the memory stage.
// Ports:
//   size          in  access size (funct3[1:0])
//   off           in  raw byte offset of the effective address
//   store_data    in  store data from execute
//   load_off      in  byte offset captured for the access in flight
//   load_data     in  raw read data from memory
//   eff_off       out offset actually used (H clears bit 0, W clears both bits)
//   be            out byte enables
//   wdata         out lane-replicated store data
//   load_shifted  out read data shifted so the addressed byte sits at [7:0]
//   misalign_trap out access must not be issued (only with MEM_MISALIGN_TRAP_EN)
// Configuration: MEM_MISALIGN_TRAP_EN enables trapping of misaligned H/W accesses;
// when undefined, misaligned accesses are silently aligned down.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]       size,
    input  logic [OFF_W-1:0] off,
    input  logic [31:0]      store_data,
    input  logic [OFF_W-1:0] load_off,
    input  logic [31:0]      load_data,
    output logic [OFF_W-1:0] eff_off,
    output logic [BE_W-1:0]  be,
    output logic [31:0]      wdata,
    output logic [31:0]      load_shifted,
    output logic             misalign_trap
);

    // Size decode: anything other than B or H is treated as a word access
    always_comb begin
        eff_off = '0;
        be      = 4'b1111;
        wdata   = store_data;
        case (size)
            SIZE_B: begin
                eff_off = off;
                be      = 4'b0001 << off;
                wdata   = {4{store_data[7:0]}};
            end
            SIZE_H: begin
                eff_off = {off[1], 1'b0};
                be      = 4'b0011 << {off[1], 1'b0};
                wdata   = {2{store_data[15:0]}};
            end
            default: begin
                eff_off = '0;
                be      = 4'b1111;
                wdata   = store_data;
            end
        endcase
    end

    // Bring the addressed byte down to bit 0; extension happens downstream
    assign load_shifted = load_data >> {load_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign_trap = 1'b0;
        case (size)
            SIZE_B:  misalign_trap = 1'b0;
            SIZE_H:  misalign_trap = off[0];
            default: misalign_trap = (off != 2'b00);
        endcase
    end
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Pipeline memory stage: issues loads/stores on the data-memory bus, stalls the
// upstream stages while an access is in flight, aborts on timeout, and registers
// results toward write-back.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   valid_ex, mem_rd_ex, mem_wr_ex, funct3_ex, alu_res_ex, rs2_data_ex,
//   gpr_we_ex, addr_rd_ex    instruction from execute
//   dmem                     data-memory bus (mem_stage_if.master)
//   stall_mem                upstream holds its outputs while 1
//   funct3_mem_wb, mem_mem_wb, gpr_we_mem, addr_rd_mem,
//   data_rd_mem, data_rd_mem_load   registered write-back outputs
//   mem_err                  one-cycle pulse on timeout or misalign trap
// Parameter TIMEOUT_CYCLES: ACCESS cycles to wait for ack before aborting.
// Configuration: MEM_MISALIGN_TRAP_EN (handled inside mem_align).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_ex,
    input  logic        mem_rd_ex,
    input  logic        mem_wr_ex,
    input  logic [2:0]  funct3_ex,
    input  logic [31:0] alu_res_ex,
    input  logic [31:0] rs2_data_ex,
    input  logic        gpr_we_ex,
    input  logic [4:0]  addr_rd_ex,
    mem_stage_if.master dmem,
    output logic        stall_mem,
    output logic [2:0]  funct3_mem_wb,
    output logic        mem_mem_wb,
    output logic        gpr_we_mem,
    output logic [4:0]  addr_rd_mem,
    output logic [31:0] data_rd_mem,
    output logic [31:0] data_rd_mem_load,
    output logic        mem_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Instruction captured for the access in flight
    logic [31:0]      alu_q;
    logic [2:0]       funct3_q;
    logic [4:0]       rd_q;
    logic             gpr_we_q;
    logic             load_q;
    logic [OFF_W-1:0] off_q;

    logic             is_mem_ex;
    logic [OFF_W-1:0] eff_off;
    logic [BE_W-1:0]  be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      load_shifted;
    logic             misalign_trap;

    assign is_mem_ex = mem_rd_ex | mem_wr_ex;

    mem_align u_align (
        .size          (funct3_ex[1:0]),
        .off           (alu_res_ex[1:0]),
        .store_data    (rs2_data_ex),
        .load_off      (off_q),
        .load_data     (dmem.rdata),
        .eff_off       (eff_off),
        .be            (be_c),
        .wdata         (wdata_c),
        .load_shifted  (load_shifted),
        .misalign_trap (misalign_trap)
    );

    // Stall is combinational so execute holds in the same cycle it presents a
    // memory op; it releases in the ack cycle so the next instruction flows in.
    always_comb begin
        stall_mem = 1'b0;
        if (state == ST_IDLE)
            stall_mem = valid_ex && is_mem_ex && !misalign_trap;
        else
            stall_mem = !dmem.ack;
    end

    // FSM with registered bus and write-back outputs. gpr_we_mem, mem_mem_wb
    // and mem_err default to 0 each cycle so every path that does not
    // complete an instruction produces a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            dmem.req         <= 1'b0;
            dmem.we          <= 1'b0;
            dmem.addr        <= '0;
            dmem.be          <= '0;
            dmem.wdata       <= '0;
            alu_q            <= '0;
            funct3_q         <= '0;
            rd_q             <= '0;
            gpr_we_q         <= 1'b0;
            load_q           <= 1'b0;
            off_q            <= '0;
            funct3_mem_wb    <= '0;
            mem_mem_wb       <= 1'b0;
            gpr_we_mem       <= 1'b0;
            addr_rd_mem      <= '0;
            data_rd_mem      <= '0;
            data_rd_mem_load <= '0;
            mem_err          <= 1'b0;
        end else begin
            mem_err    <= 1'b0;
            gpr_we_mem <= 1'b0;
            mem_mem_wb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_ex && is_mem_ex) begin
                        if (misalign_trap) begin
                            mem_err <= 1'b1;
                        end else begin
                            state      <= ST_ACCESS;
                            cnt        <= '0;
                            dmem.req   <= 1'b1;
                            dmem.we    <= mem_wr_ex;
                            dmem.addr  <= {alu_res_ex[31:2], 2'b00};
                            dmem.be    <= be_c;
                            dmem.wdata <= wdata_c;
                            alu_q      <= alu_res_ex;
                            funct3_q   <= funct3_ex;
                            rd_q       <= addr_rd_ex;
                            gpr_we_q   <= gpr_we_ex;
                            load_q     <= !mem_wr_ex;
                            off_q      <= eff_off;
                        end
                    end else if (valid_ex) begin
                        data_rd_mem   <= alu_res_ex;
                        addr_rd_mem   <= addr_rd_ex;
                        funct3_mem_wb <= funct3_ex;
                        gpr_we_mem    <= gpr_we_ex;
                    end
                end
                ST_ACCESS: begin
                    // Ack is tested first so it wins over a same-cycle timeout
                    if (dmem.ack) begin
                        state            <= ST_IDLE;
                        dmem.req         <= 1'b0;
                        dmem.we          <= 1'b0;
                        dmem.be          <= '0;
                        data_rd_mem      <= alu_q;
                        data_rd_mem_load <= load_shifted;
                        addr_rd_mem      <= rd_q;
                        funct3_mem_wb    <= funct3_q;
                        mem_mem_wb       <= load_q;
                        gpr_we_mem       <= load_q & gpr_we_q;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ST_IDLE;
                        dmem.req <= 1'b0;
                        dmem.we  <= 1'b0;
                        dmem.be  <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed table-driven bench for mem_stage plus hand-written sequences for
// reset, idle ack, timeout, ack on the last cycle, reset during ACCESS and
// misaligned word access (both MEM_MISALIGN_TRAP_EN builds).
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        valid_ex;
    logic        mem_rd_ex;
    logic        mem_wr_ex;
    logic [2:0]  funct3_ex;
    logic [31:0] alu_res_ex;
    logic [31:0] rs2_data_ex;
    logic        gpr_we_ex;
    logic [4:0]  addr_rd_ex;
    logic        stall_mem;
    logic [2:0]  funct3_mem_wb;
    logic        mem_mem_wb;
    logic        gpr_we_mem;
    logic [4:0]  addr_rd_mem;
    logic [31:0] data_rd_mem;
    logic [31:0] data_rd_mem_load;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage_if dmem_bus ();

    mem_stage #(.TIMEOUT_CYCLES(15)) dut (
        .clk              (clk),
        .rst              (rst),
        .valid_ex         (valid_ex),
        .mem_rd_ex        (mem_rd_ex),
        .mem_wr_ex        (mem_wr_ex),
        .funct3_ex        (funct3_ex),
        .alu_res_ex       (alu_res_ex),
        .rs2_data_ex      (rs2_data_ex),
        .gpr_we_ex        (gpr_we_ex),
        .addr_rd_ex       (addr_rd_ex),
        .dmem             (dmem_bus),
        .stall_mem        (stall_mem),
        .funct3_mem_wb    (funct3_mem_wb),
        .mem_mem_wb       (mem_mem_wb),
        .gpr_we_mem       (gpr_we_mem),
        .addr_rd_mem      (addr_rd_mem),
        .data_rd_mem      (data_rd_mem),
        .data_rd_mem_load (data_rd_mem_load),
        .mem_err          (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_rd;
        logic        is_wr;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        gwe;
        logic [4:0]  rd_idx;
        int          ack_after;
        logic [3:0]  e_be;
        logic [31:0] e_daddr;
        logic [31:0] e_wdata;
        int          e_stalls;
        logic [31:0] e_load;
        logic        e_gwe;
        logic        e_memwb;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        valid_ex    = 1'b0;
        mem_rd_ex   = 1'b0;
        mem_wr_ex   = 1'b0;
        funct3_ex   = 3'b000;
        alu_res_ex  = 32'h0;
        rs2_data_ex = 32'h0;
        gpr_we_ex   = 1'b0;
        addr_rd_ex  = 5'd0;
    endtask

    task automatic driveEx(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] rs2,
                           input logic gwe, input logic [4:0] rd_idx);
        valid_ex    = 1'b1;
        mem_rd_ex   = rd;
        mem_wr_ex   = wr;
        funct3_ex   = f3;
        alu_res_ex  = alu;
        rs2_data_ex = rs2;
        gpr_we_ex   = gwe;
        addr_rd_ex  = rd_idx;
    endtask

    // One full instruction: present it, answer the bus after ack_after idle
    // ACCESS cycles, then compare bus fields, stall count and write-back.
    task automatic applyStimulus(input vec_t v, input int idx);
        int  acc;
        int  stalls;
        bit  done;
        string tag;
        acc    = 0;
        stalls = 0;
        done   = 0;
        tag    = $sformatf("vec%0d", idx);
        @(negedge clk);
        driveEx(v.is_rd, v.is_wr, v.f3, v.alu, v.rs2, v.gwe, v.rd_idx);
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmem_bus.req) begin
                if (acc == 0) begin
                    checkOutput({tag, "_addr"},  dmem_bus.addr,  v.e_daddr);
                    checkOutput({tag, "_be"},    32'(dmem_bus.be), 32'(v.e_be));
                    checkOutput({tag, "_we"},    32'(dmem_bus.we), 32'(v.is_wr));
                    if (v.is_wr)
                        checkOutput({tag, "_wdata"}, dmem_bus.wdata, v.e_wdata);
                end
                acc++;
                dmem_bus.ack   = (acc == v.ack_after + 1);
                dmem_bus.rdata = v.rdata;
            end
            #1;
            if (stall_mem) begin
                stalls++;
            end else begin
                done = 1;
                break;
            end
            @(negedge clk);
            dmem_bus.ack = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_complete: stall still high after 40 cycles", tag);
            dmem_bus.ack = 1'b0;
            clearInputs();
            return;
        end
        @(posedge clk);
        #1;
        dmem_bus.ack = 1'b0;
        clearInputs();
        checkOutput({tag, "_stalls"},   32'(stalls), 32'(v.e_stalls));
        checkOutput({tag, "_data_rd"},  data_rd_mem, v.alu);
        checkOutput({tag, "_addr_rd"},  32'(addr_rd_mem), 32'(v.rd_idx));
        checkOutput({tag, "_funct3"},   32'(funct3_mem_wb), 32'(v.f3));
        checkOutput({tag, "_gpr_we"},   32'(gpr_we_mem), 32'(v.e_gwe));
        checkOutput({tag, "_mem_wb"},   32'(mem_mem_wb), 32'(v.e_memwb));
        checkOutput({tag, "_mem_err"},  32'(mem_err), 32'h0);
        checkOutput({tag, "_req_off"},  32'(dmem_bus.req), 32'h0);
        if (v.is_rd)
            checkOutput({tag, "_load"}, data_rd_mem_load, v.e_load);
        @(posedge clk);
        #1;
        checkOutput({tag, "_bubble"}, 32'(gpr_we_mem), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reqCycles;
        vec_t mv;

        //            rd wr f3      alu          rs2           rdata         gwe rd    ack be       daddr        wdata         stl load          gwe memwb
        vecs[0] = '{1'b0,1'b0,3'b000,32'h00001234,32'h0,       32'h0,        1'b1,5'd5, 0,4'b0000,32'h0,       32'h0,        0, 32'h0,        1'b1,1'b0};
        vecs[1] = '{1'b0,1'b1,3'b000,32'h00000103,32'hAB,      32'h0,        1'b1,5'd9, 2,4'b1000,32'h100,     32'hABABABAB, 3, 32'h0,        1'b0,1'b0};
        vecs[2] = '{1'b1,1'b0,3'b001,32'h00000202,32'h11223344,32'h8001FFFF, 1'b1,5'd7, 0,4'b1100,32'h200,     32'h33443344, 1, 32'h00008001, 1'b1,1'b1};
        vecs[3] = '{1'b0,1'b1,3'b010,32'h00000040,32'hDEADBEEF,32'h0,        1'b0,5'd3, 1,4'b1111,32'h40,      32'hDEADBEEF, 2, 32'h0,        1'b0,1'b0};
        vecs[4] = '{1'b1,1'b0,3'b100,32'h00000055,32'h0,       32'h11223344, 1'b1,5'd12,3,4'b0010,32'h54,      32'h0,        4, 32'h00112233, 1'b1,1'b1};
        vecs[5] = '{1'b0,1'b1,3'b001,32'h0000001E,32'h0000BEEF,32'h0,        1'b1,5'd1, 0,4'b1100,32'h1C,      32'hBEEFBEEF, 1, 32'h0,        1'b0,1'b0};
        vecs[6] = '{1'b1,1'b0,3'b000,32'h00000003,32'h0,       32'hAA000000, 1'b1,5'd20,0,4'b1000,32'h0,       32'h0,        1, 32'h000000AA, 1'b1,1'b1};
        vecs[7] = '{1'b1,1'b0,3'b101,32'h00001002,32'h0,       32'hBEEF0000, 1'b0,5'd4, 1,4'b1100,32'h1000,    32'h0,        2, 32'h0000BEEF, 1'b0,1'b1};
        vecs[8] = '{1'b0,1'b0,3'b111,32'hFFFFFFFF,32'h0,       32'h0,        1'b0,5'd31,0,4'b0000,32'h0,       32'h0,        0, 32'h0,        1'b0,1'b0};

        clearInputs();
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("[TB] checking reset state");
        checkOutput("rst_req",       32'(dmem_bus.req), 32'h0);
        checkOutput("rst_we",        32'(dmem_bus.we), 32'h0);
        checkOutput("rst_be",        32'(dmem_bus.be), 32'h0);
        checkOutput("rst_addr",      dmem_bus.addr, 32'h0);
        checkOutput("rst_wdata",     dmem_bus.wdata, 32'h0);
        checkOutput("rst_mem_err",   32'(mem_err), 32'h0);
        checkOutput("rst_gpr_we",    32'(gpr_we_mem), 32'h0);
        checkOutput("rst_mem_wb",    32'(mem_mem_wb), 32'h0);
        checkOutput("rst_data_rd",   data_rd_mem, 32'h0);
        checkOutput("rst_load",      data_rd_mem_load, 32'h0);
        checkOutput("rst_addr_rd",   32'(addr_rd_mem), 32'h0);
        checkOutput("rst_stall",     32'(stall_mem), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++)
            applyStimulus(vecs[i], i);

        $display("[TB] ack while idle");
        @(negedge clk);
        dmem_bus.ack = 1'b1;
        #1;
        checkOutput("idle_ack_stall", 32'(stall_mem), 32'h0);
        @(posedge clk);
        #1;
        dmem_bus.ack = 1'b0;
        checkOutput("idle_ack_req",    32'(dmem_bus.req), 32'h0);
        checkOutput("idle_ack_gpr_we", 32'(gpr_we_mem), 32'h0);
        checkOutput("idle_ack_err",    32'(mem_err), 32'h0);

        $display("[TB] timeout with no ack");
        @(negedge clk);
        driveEx(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 5'd8);
        @(posedge clk);
        #1;
        clearInputs();
        reqCycles = 0;
        for (int n = 0; n < 40 && dmem_bus.req; n++) begin
            reqCycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("timeout_req_cycles", 32'(reqCycles), 32'd15);
        checkOutput("timeout_err",        32'(mem_err), 32'h1);
        checkOutput("timeout_gpr_we",     32'(gpr_we_mem), 32'h0);
        checkOutput("timeout_stall",      32'(stall_mem), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("timeout_err_pulse",  32'(mem_err), 32'h0);
        checkOutput("timeout_req_idle",   32'(dmem_bus.req), 32'h0);

        $display("[TB] ack on the last timeout cycle");
        @(negedge clk);
        driveEx(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b1, 5'd11);
        @(posedge clk);
        #1;
        clearInputs();
        reqCycles = 0;
        for (int n = 0; n < 40 && dmem_bus.req; n++) begin
            reqCycles++;
            if (reqCycles == 15) begin
                dmem_bus.ack   = 1'b1;
                dmem_bus.rdata = 32'h5A5A5A5A;
            end
            @(posedge clk);
            #1;
            dmem_bus.ack = 1'b0;
            if (reqCycles == 15)
                break;
        end
        checkOutput("late_ack_cycles", 32'(reqCycles), 32'd15);
        checkOutput("late_ack_req",    32'(dmem_bus.req), 32'h0);
        checkOutput("late_ack_err",    32'(mem_err), 32'h0);
        checkOutput("late_ack_gpr_we", 32'(gpr_we_mem), 32'h1);
        checkOutput("late_ack_mem_wb", 32'(mem_mem_wb), 32'h1);
        checkOutput("late_ack_load",   data_rd_mem_load, 32'h5A5A5A5A);
        checkOutput("late_ack_rd",     32'(addr_rd_mem), 32'd11);

        $display("[TB] reset during access");
        @(negedge clk);
        driveEx(1'b0, 1'b1, 3'b010, 32'h88, 32'h12345678, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        clearInputs();
        checkOutput("rst_access_req_before", 32'(dmem_bus.req), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_access_req", 32'(dmem_bus.req), 32'h0);
        checkOutput("rst_access_err", 32'(mem_err), 32'h0);
        checkOutput("rst_access_be",  32'(dmem_bus.be), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_access_stall", 32'(stall_mem), 32'h0);

        $display("[TB] misaligned word load");
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        driveEx(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 1'b1, 5'd6);
        #1;
        checkOutput("trap_stall", 32'(stall_mem), 32'h0);
        @(posedge clk);
        #1;
        clearInputs();
        checkOutput("trap_req",    32'(dmem_bus.req), 32'h0);
        checkOutput("trap_err",    32'(mem_err), 32'h1);
        checkOutput("trap_gpr_we", 32'(gpr_we_mem), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("trap_err_pulse", 32'(mem_err), 32'h0);
        checkOutput("trap_req_after", 32'(dmem_bus.req), 32'h0);
`else
        mv = '{1'b1,1'b0,3'b010,32'h00000301,32'h0,32'h12345678,1'b1,5'd6,0,4'b1111,32'h300,32'h0,1,32'h12345678,1'b1,1'b1};
        applyStimulus(mv, 100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
